// File: rtl/slice_permuter_if.sv
// Slice stream bundle: input handshake, output handshake.
// Master drives slices in and takes results; slave is the permuter.
interface slice_permuter_if #(
  parameter int W = 25
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/slice_permuter.sv
// Buffers a block of DEPTH slices, then drains them in forward
// or reverse order, optionally applying the pi bit permutation.
module slice_permuter #(
  parameter int DIM   = 5,
  parameter int DEPTH = 64,
  parameter int OFF   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  output logic       busy,
  slice_permuter_if.slave bus
);
  localparam int W  = DIM * DIM;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [AW-1:0]  wr_cnt;
  logic [AW-1:0]  rd_cnt;
  logic [1:0]     mode_q;
  logic [W-1:0]   buffer [DEPTH];

  logic           acc;
  logic           last_acc;
  logic           out_hs;
  logic           last_out;
  logic [AW-1:0]  seq_nxt;
  logic [AW-1:0]  rd_addr;
  logic [W-1:0]   raw;
  logic [W-1:0]   pi_raw;
  logic [W-1:0]   slice_nxt;

  assign acc      = bus.in_valid && bus.in_ready && !rst;
  assign last_acc = acc && (wr_cnt == AW'(DEPTH - 1));
  assign out_hs   = bus.out_valid && bus.out_ready;
  assign last_out = out_hs && (rd_cnt == AW'(DEPTH - 1));

  // The slice shown after this cycle: first of block or next in order.
  // In reverse mode the first slice is the one arriving right now.
  assign seq_nxt = last_acc ? '0 : rd_cnt + AW'(1);
  assign rd_addr = mode_q[1] ? ~seq_nxt : seq_nxt;
  assign raw     = (last_acc && mode_q[1]) ? bus.in_data
                                           : buffer[rd_addr];

  for (genvar y = 0; y < DIM; y++) begin : g_row
    for (genvar x = 0; x < DIM; x++) begin : g_col
      localparam int U  = (x + OFF) % DIM;
      localparam int V  = (y + OFF) % DIM;
      localparam int V2 = (2 * U + 3 * V) % DIM;
      localparam int XD = (V - OFF + DIM) % DIM;
      localparam int YD = (V2 - OFF + DIM) % DIM;
      assign pi_raw[YD*DIM+XD] = raw[y*DIM+x];
    end
  end

  assign slice_nxt = mode_q[0] ? pi_raw : raw;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: fill until DEPTH accepts, drain until last output.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (acc)      state_nxt = FILL;
      FILL:    if (last_acc) state_nxt = DRAIN;
      DRAIN:   if (last_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    bus.in_ready = (state != DRAIN);
    busy         = (state != IDLE);
  end

  // Write counter and mode latch on the first accept of a block.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
      mode_q <= '0;
    end else if (acc) begin
      wr_cnt <= wr_cnt + AW'(1);
      if (state == IDLE) mode_q <= mode;
    end
  end

  // Slice storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (acc) buffer[wr_cnt] <= bus.in_data;
  end

  // Output register: load first slice on block end, advance on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else if (last_acc) begin
      rd_cnt        <= '0;
      bus.out_valid <= 1'b1;
      bus.out_last  <= 1'b0;
      bus.out_data  <= slice_nxt;
    end else if (out_hs) begin
      rd_cnt <= rd_cnt + AW'(1);
      if (last_out) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end else begin
        bus.out_data <= slice_nxt;
        bus.out_last <= (seq_nxt == AW'(DEPTH - 1));
      end
    end
  end
endmodule

// File: tb/tb_slice_permuter.sv
// Scoreboard bench for slice_permuter: random and directed blocks
// checked against a coordinate-level model of order and pi.
module tb_slice_permuter;
  localparam int DIM   = 5;
  localparam int DEPTH = 64;
  localparam int OFF   = 3;
  localparam int W     = DIM * DIM;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       busy;

  always #5 clk = ~clk;

  slice_permuter_if #(.W(W)) bus ();

  slice_permuter #(
    .DIM(DIM), .DEPTH(DEPTH), .OFF(OFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .busy(busy),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_pi(input logic [W-1:0] s);
    logic [W-1:0] r;
    int u, v, u2, v2, xp, yp;
    r = '0;
    for (int y = 0; y < DIM; y++)
      for (int x = 0; x < DIM; x++) begin
        u  = (x + OFF) % DIM;
        v  = (y + OFF) % DIM;
        u2 = v;
        v2 = (2 * u + 3 * v) % DIM;
        xp = ((u2 - OFF) % DIM + DIM) % DIM;
        yp = ((v2 - OFF) % DIM + DIM) % DIM;
        r[yp*DIM+xp] = s[y*DIM+x];
      end
    return r;
  endfunction

  // Downstream ready pattern: 0 always, 1 toggle, 2 random, 3 never.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = (bus.out_ready !== 1'b1);
      2:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Monitor: pop and compare on every output handshake.
  bit   held = 0;
  bit   post = 0;
  exp_t hv;
  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      held = 0;
      post = 0;
    end else begin
      if (post) begin
        chk("idle_after_last_valid", 32'(bus.out_valid), 0);
        chk("idle_after_last_ready", 32'(bus.in_ready), 1);
        post = 0;
      end
      if (held && bus.out_valid) begin
        chk("stall_data", 32'(bus.out_data), 32'(hv.d));
        chk("stall_last", 32'(bus.out_last), 32'(hv.l));
      end
      held = 0;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected none",
                   bus.out_data);
        end else begin
          e = q.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(e.d));
          chk("out_last", 32'(bus.out_last), 32'(e.l));
        end
        if (bus.out_last) post = 1;
      end else if (bus.out_valid) begin
        held = 1;
        hv.d = bus.out_data;
        hv.l = bus.out_last;
      end
    end
  end

  // Kind: 0 random, 1 one-hot slice 0, 2 center bit, 3 value k.
  task automatic send_block(input logic [1:0] m, input int kind,
                            input bit gaps);
    logic [W-1:0] s[DEPTH];
    logic [W-1:0] o;
    int n;
    int j;
    for (int k = 0; k < DEPTH; k++) begin
      case (kind)
        1:       s[k] = (k == 0) ? W'(1) : '0;
        2:       s[k] = W'(25'h0001000);
        3:       s[k] = W'(k);
        default: s[k] = W'($urandom);
      endcase
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (gaps && k > 0 && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = s[k];
      mode = (k == 0) ? m : 2'($urandom);
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 2000) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got none expected accept");
        return;
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      j = m[1] ? DEPTH - 1 - i : i;
      o = m[0] ? ref_pi(s[j]) : s[j];
      q.push_back('{d: o, l: (i == DEPTH - 1)});
    end
    chk("latency_valid", 32'(bus.out_valid), 1);
    chk("drain_in_ready", 32'(bus.in_ready), 0);
    chk("drain_busy", 32'(busy), 1);
  endtask

  task automatic drain_wait();
    int n;
    n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d left expected 0",
               q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_out_last"}, 32'(bus.out_last), 0);
    chk({tag, "_out_data"}, 32'(bus.out_data), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    rdy_mode = 0;
    send_block(2'b01, 1, 0);
    chk("pi_bit0_to_bit10", 32'(bus.out_data), 32'h400);
    bus.in_valid = 1'b0;
    drain_wait();

    send_block(2'b01, 2, 0);
    chk("pi_center_fixed", 32'(bus.out_data), 32'h1000);
    send_block(2'b10, 3, 0);
    chk("reverse_first", 32'(bus.out_data), 63);
    rdy_mode = 1;
    send_block(2'b00, 0, 0);
    bus.in_valid = 1'b0;
    drain_wait();

    rdy_mode = 0;
    for (int k = 0; k < 30; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom);
      mode = 2'b11;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cycle_out_valid", 32'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check_reset_state("rst_fill");
    send_block(2'b00, 0, 0);

    rdy_mode = 2;
    for (int b = 0; b < 6; b++)
      send_block(2'($urandom), 0, 1);
    bus.in_valid = 1'b0;
    drain_wait();

    rdy_mode = 3;
    send_block(2'b11, 0, 0);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    check_reset_state("rst_drain");
    rdy_mode = 0;
    send_block(2'b01, 0, 0);
    bus.in_valid = 1'b0;
    drain_wait();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/slice_permuter.md
SLICE_PERMUTER -- requirements
Module: slice_permuter

Interface
REQ-001 The block SHALL have parameter DIM, default 5: matrix dimension; DIM odd, 3..7; slice width W = DIM*DIM bits.
REQ-002 The block SHALL have parameter DEPTH, default 64: slices per block; power of two, 2..256.
REQ-003 The block SHALL have parameter OFF, default 3: coordinate offset for pi mapping, 0..DIM-1.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset; synchronous, active-high.
REQ-006 The block SHALL have port mode, input, 2 bits: bit0 = apply pi per slice; bit1 = emit slices in reverse order.
REQ-007 The block SHALL have port in_valid, input, 1 bit: input slice present.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts input this cycle.
REQ-009 The block SHALL have port in_data, input, W bits: slice, bit index i = y*DIM + x.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts output.
REQ-012 The block SHALL have port out_data, output, W bits: processed slice, registered.
REQ-013 The block SHALL have port out_last, output, 1 bit: out_data is the final slice of the block.
REQ-014 The block SHALL have port busy, output, 1 bit: state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, FILL and DRAIN; in_ready = 1 in IDLE and FILL and 0 in DRAIN.
REQ-016 An input handshake SHALL occur on in_valid & in_ready; the slice is written to buffer[wr_cnt] and wr_cnt increments.
REQ-017 mode SHALL be latched on the first input handshake of a block (IDLE to FILL) and held until the block fully drains; mode changes mid-block SHALL be ignored.
REQ-018 The handshake that accepts slice DEPTH-1 SHALL move the FSM to DRAIN; the cycle after, out_valid = 1 with the first output slice (latency 1 cycle).
REQ-019 The output slice order SHALL be 0..DEPTH-1 if latched mode[1] = 0, and DEPTH-1..0 if mode[1] = 1.
REQ-020 pi (latched mode[0] = 1) SHALL move each input bit (x,y) as follows: u=(x+OFF) mod DIM, v=(y+OFF) mod DIM; u2=v, v2=(2u+3v) mod DIM; x'=(u2-OFF) mod DIM, y'=(v2-OFF) mod DIM, both non-negative; out bit y'*DIM+x' = in bit y*DIM+x. With mode[0] = 0, bits SHALL pass unchanged.
REQ-021 An output handshake SHALL occur on out_valid & out_ready; out_data and out_last SHALL stay stable while out_valid & !out_ready.
REQ-022 out_last SHALL be 1 only with the DEPTH-th output slice of a block.
REQ-023 On the handshake of the last slice, the FSM SHALL go to IDLE, with out_valid = 0 and in_ready = 1 the next cycle; no bubble beyond this.
REQ-024 in_valid during DRAIN SHALL be ignored, with no buffer write.
REQ-025 in_valid = 0 in FILL SHALL hold state indefinitely.
REQ-026 wr_cnt and rd_cnt SHALL be clog2(DEPTH) bits and SHALL wrap to 0 at block end.

Reset
REQ-027 While rst = 1 the block SHALL set state to IDLE, counters and latched mode to 0, out_valid, out_last and busy to 0, and out_data to 0; in_ready = 1 from the first cycle after reset.
REQ-028 rst SHALL take priority over all handshakes; reset mid-FILL or mid-DRAIN SHALL discard the partial block; buffer contents need not be cleared.

Verification
REQ-029 DIM=5, OFF=3, DEPTH=64, mode=01, slice 0 = 25'h0000001, rest 0 -> first out_data = 25'h0000400 (bit 0 to bit 10), out_valid 1 cycle after 64th accept.
REQ-030 mode=01, slice = 25'h0001000 (center bit 12) -> out_data = 25'h0001000 (fixed point).
REQ-031 mode=10, slices k = k (k = 0..63) -> outputs 63, 62, ..., 0; out_last only on value 0; 128 handshake cycles with out_ready = 1.
REQ-032 mode=00, out_ready toggling 1010..., in_valid held high in DRAIN -> outputs equal inputs in order; data stable during stalls; no extra buffer writes.
REQ-033 rst asserted after 30 accepts, then a full block with mode=00 -> only the new block's 64 slices emitted; out_valid = 0 throughout the reset cycle.
REQ-034 Second block presented back-to-back -> first accept occurs 1 cycle after the previous last output handshake; mode changed mid-FILL has no effect.
